// File: rtl/pga_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pga_pkg
// Purpose  : Shared state encoding, default timing constants and helpers for
//            the PGA gain-setting SPI controller.
// Revision : 1.0 - initial release
// ============================================================================
package pga_pkg;

   // Controller states; the error path goes straight from IDLE to GAP.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } pga_state_t;

   localparam int c_def_data_w    = 8;
   localparam int c_def_num_ch    = 4;
   localparam int c_def_clk_div   = 2;
   localparam int c_def_cs_setup  = 1;
   localparam int c_def_cs_hold   = 1;
   localparam int c_def_cs_gap    = 2;
   localparam int c_def_msb_first = 1;

   // Width of the phase timer used for SETUP/HOLD/GAP.
   localparam int c_tcnt_w = 16;

   // Channel-select width, never narrower than one bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pga_spi_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : pga_spi_ctrl_if
// Purpose   : Command, response and SPI pin bundle of the PGA controller.
// Revision  : 1.0 - initial release
// ============================================================================
interface pga_spi_ctrl_if
   import pga_pkg::*;
#(
   parameter int DATA_W = c_def_data_w,
   parameter int NUM_CH = c_def_num_ch
);
   localparam int c_ch_w = ch_width(NUM_CH);

   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic [c_ch_w-1:0] cmd_ch_i;
   logic [DATA_W-1:0] cmd_data_i;
   logic              spi_sclk_o;
   logic [NUM_CH-1:0] spi_cs_n_o;
   logic              spi_mosi_o;
   logic              spi_miso_i;
   logic              rsp_valid_o;
   logic [DATA_W-1:0] rsp_data_o;
   logic              rsp_err_o;

   // Controller side
   modport slave (
      input  cmd_valid_i, cmd_ch_i, cmd_data_i, spi_miso_i,
      output cmd_ready_o, spi_sclk_o, spi_cs_n_o, spi_mosi_o,
             rsp_valid_o, rsp_data_o, rsp_err_o
   );

   // Host / board side
   modport master (
      output cmd_valid_i, cmd_ch_i, cmd_data_i, spi_miso_i,
      input  cmd_ready_o, spi_sclk_o, spi_cs_n_o, spi_mosi_o,
             rsp_valid_o, rsp_data_o, rsp_err_o
   );
endinterface
`default_nettype wire

// File: rtl/spi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_tick_gen
// Purpose  : Bit-phase timer. Each bit is CLK_DIV cycles low then CLK_DIV
//            cycles high; flags the sclk rise and the last cycle of a bit.
// Revision : 1.0 - initial release
// ============================================================================
module spi_tick_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic sck,
   input  logic rst,
   input  logic en,
   output logic sclk_lvl,
   output logic rise,
   output logic bit_done
);
   localparam int c_cnt_w = $clog2(2 * CLK_DIV);

   logic [c_cnt_w-1:0] r_cnt;

   // Phase counter: held at zero while disabled, wraps at the end of each bit.
   always_ff @(posedge sck or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (!en || bit_done)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   assign sclk_lvl = en && (r_cnt >= c_cnt_w'(CLK_DIV));
   assign rise     = en && (r_cnt == c_cnt_w'(CLK_DIV));
   assign bit_done = en && (r_cnt == c_cnt_w'(2 * CLK_DIV - 1));
endmodule
`default_nettype wire

// File: rtl/pga_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pga_spi_ctrl
// Purpose  : Writes a gain code to one of NUM_CH PGAs over mode-0 SPI and
//            returns the word shifted back on MISO. All pin outputs are
//            registered, so they trail the internal state by one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pga_spi_ctrl
   import pga_pkg::*;
#(
   parameter int DATA_W    = c_def_data_w,
   parameter int NUM_CH    = c_def_num_ch,
   parameter int CLK_DIV   = c_def_clk_div,
   parameter int CS_SETUP  = c_def_cs_setup,
   parameter int CS_HOLD   = c_def_cs_hold,
   parameter int CS_GAP    = c_def_cs_gap,
   parameter int MSB_FIRST = c_def_msb_first
) (
   input  logic          sck,
   input  logic          rst,
   pga_spi_ctrl_if.slave bus
);
   localparam int c_ch_w  = ch_width(NUM_CH);
   localparam int c_bit_w = $clog2(DATA_W);
   localparam logic [c_tcnt_w-1:0] c_setup_last = c_tcnt_w'(CS_SETUP - 1);
   localparam logic [c_tcnt_w-1:0] c_hold_last  = c_tcnt_w'(CS_HOLD - 1);
   localparam logic [c_tcnt_w-1:0] c_gap_last   = c_tcnt_w'(CS_GAP - 1);

   pga_state_t          r_state, w_state_next;
   logic [c_tcnt_w-1:0] r_tcnt;
   logic                w_tcnt_clr;
   logic [c_ch_w-1:0]   r_ch;
   logic                r_err;
   logic [DATA_W-1:0]   r_tx, r_rx, r_rsp_data;
   logic [c_bit_w-1:0]  r_bit;
   logic                w_accept, w_bad_ch, w_in_frame, w_last_bit, w_tx_bit;
   logic                w_shift_en, w_sclk_lvl, w_rise, w_bit_done;
   logic [NUM_CH-1:0]   w_cs_n, r_cs_n;
   logic                r_sclk, r_mosi, r_rsp_valid, r_rsp_err, r_ready;

   assign w_accept   = bus.cmd_valid_i && r_ready;
   assign w_bad_ch   = int'(bus.cmd_ch_i) >= NUM_CH;
   assign w_in_frame = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
   assign w_shift_en = (r_state == ST_SHIFT);
   assign w_last_bit = (r_bit == c_bit_w'(DATA_W - 1));
   assign w_tx_bit   = (MSB_FIRST != 0) ? r_tx[DATA_W-1] : r_tx[0];

   spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .sck      (sck),
      .rst      (rst),
      .en       (w_shift_en),
      .sclk_lvl (w_sclk_lvl),
      .rise     (w_rise),
      .bit_done (w_bit_done)
   );

   // State register.
   always_ff @(posedge sck or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode; every transition restarts the phase timer.
   always_comb begin
      w_state_next = r_state;
      w_tcnt_clr   = 1'b0;
      case (r_state)
         ST_IDLE:  if (w_accept) begin
                      w_state_next = w_bad_ch ? ST_GAP : ST_SETUP;
                      w_tcnt_clr   = 1'b1;
                   end
         ST_SETUP: if (r_tcnt == c_setup_last) begin
                      w_state_next = ST_SHIFT;
                      w_tcnt_clr   = 1'b1;
                   end
         ST_SHIFT: if (w_bit_done && w_last_bit) begin
                      w_state_next = ST_HOLD;
                      w_tcnt_clr   = 1'b1;
                   end
         ST_HOLD:  if (r_tcnt == c_hold_last) begin
                      w_state_next = ST_GAP;
                      w_tcnt_clr   = 1'b1;
                   end
         ST_GAP:   if (r_tcnt == c_gap_last) begin
                      w_state_next = ST_IDLE;
                      w_tcnt_clr   = 1'b1;
                   end
         default:  begin
                      w_state_next = ST_IDLE;
                      w_tcnt_clr   = 1'b1;
                   end
      endcase
   end

   // Phase timer for SETUP/HOLD/GAP.
   always_ff @(posedge sck or posedge rst) begin
      if (rst)
         r_tcnt <= '0;
      else if (w_tcnt_clr || (r_state == ST_IDLE))
         r_tcnt <= '0;
      else
         r_tcnt <= r_tcnt + 1'b1;
   end

   // Command latch, TX shifter (advances after each bit but the last) and RX assembly.
   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         r_ch  <= '0;
         r_err <= 1'b0;
         r_tx  <= '0;
         r_rx  <= '0;
         r_bit <= '0;
      end else if (w_accept) begin
         r_ch  <= bus.cmd_ch_i;
         r_err <= w_bad_ch;
         r_tx  <= bus.cmd_data_i;
         r_rx  <= '0;
         r_bit <= '0;
      end else if (w_shift_en) begin
         if (w_rise)
            r_rx <= (MSB_FIRST != 0) ? {r_rx[DATA_W-2:0], bus.spi_miso_i}
                                     : {bus.spi_miso_i, r_rx[DATA_W-1:1]};
         if (w_bit_done && !w_last_bit) begin
            r_tx  <= (MSB_FIRST != 0) ? {r_tx[DATA_W-2:0], 1'b0} : {1'b0, r_tx[DATA_W-1:1]};
            r_bit <= r_bit + 1'b1;
         end
      end
   end

   // Only the latched channel may be selected, and only inside a frame.
   always_comb begin
      w_cs_n = '1;
      for (int i = 0; i < NUM_CH; i++)
         if (w_in_frame && (int'(r_ch) == i)) w_cs_n[i] = 1'b0;
   end

   // Registered pins and response; the response fires on the first GAP cycle.
   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         r_cs_n      <= '1;
         r_sclk      <= 1'b0;
         r_mosi      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
         r_ready     <= 1'b1;
      end else begin
         r_cs_n      <= w_cs_n;
         r_sclk      <= w_sclk_lvl;
         r_mosi      <= w_in_frame ? w_tx_bit : 1'b0;
         r_ready     <= (r_state == ST_IDLE) && !w_accept;
         r_rsp_valid <= 1'b0;
         if ((r_state == ST_GAP) && (r_tcnt == '0)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err;
            r_rsp_data  <= r_err ? '0 : r_rx;
         end
      end
   end

   assign bus.cmd_ready_o = r_ready;
   assign bus.spi_cs_n_o  = r_cs_n;
   assign bus.spi_sclk_o  = r_sclk;
   assign bus.spi_mosi_o  = r_mosi;
   assign bus.rsp_valid_o = r_rsp_valid;
   assign bus.rsp_err_o   = r_rsp_err;
   assign bus.rsp_data_o  = r_rsp_data;
endmodule
`default_nettype wire

// File: doc/pga_spi_ctrl.md
PGA_SPI_CTRL -- requirements
Module: pga_spi_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per transfer, legal range 2..32.
REQ-002 SHALL have parameter NUM_CH, default 4: number of PGA chip selects, legal range 1..16.
REQ-003 SHALL have parameter CLK_DIV, default 2: sck cycles per SPI clock half-period, minimum 1.
REQ-004 SHALL have parameters CS_SETUP (default 1), CS_HOLD (default 1) and CS_GAP (default 2), each measured in sck cycles with minimum 1.
REQ-005 SHALL have parameter MSB_FIRST, default 1: 1 shifts the MSB first, 0 shifts the LSB first.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: sck input 1 system clock (all flops rising edge); rst input 1 async active-high reset.
REQ-007 Port cmd_valid_i, input, 1 bit: command request.
REQ-008 Port cmd_ready_o, output, 1 bit: block can accept a command.
REQ-009 Port cmd_ch_i, input, $clog2(NUM_CH) bits (minimum 1): target channel.
REQ-010 Port cmd_data_i, input, DATA_W bits: gain code to send.
REQ-011 Port spi_sclk_o, output, 1 bit: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 Port spi_cs_n_o, output, NUM_CH bits: active-low chip selects.
REQ-013 Port spi_mosi_o, output, 1 bit: serial data out.
REQ-014 Port spi_miso_i, input, 1 bit: serial readback in.
REQ-015 Port rsp_valid_o, output, 1 bit: one-cycle completion pulse.
REQ-016 Port rsp_data_o, output, DATA_W bits: captured readback data.
REQ-017 Port rsp_err_o, output, 1 bit: command rejected, qualified by rsp_valid_o.

Function
REQ-018 A command SHALL be accepted on a rising sck edge where cmd_valid_i && cmd_ready_o; cmd_ready_o SHALL be 1 only in state IDLE.
REQ-019 On accept, cmd_ch_i and cmd_data_i SHALL be latched; later changes to these inputs SHALL NOT affect the transfer in progress.
REQ-020 A command with cmd_ch_i >= NUM_CH SHALL NOT assert any chip select; rsp_valid_o and rsp_err_o SHALL both be 1 in the cycle after accept, rsp_data_o SHALL be 0, and the block SHALL pass through GAP before returning to IDLE.
REQ-021 The FSM SHALL have states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE; the error path is IDLE -> GAP.
REQ-022 In SETUP (CS_SETUP cycles): spi_cs_n_o[ch]=0, spi_sclk_o=0, spi_mosi_o = first bit.
REQ-023 In SHIFT, each bit SHALL take CLK_DIV cycles with sclk low followed by CLK_DIV cycles with sclk high; SHIFT SHALL last 2*CLK_DIV*DATA_W cycles in total.
REQ-024 spi_miso_i SHALL be sampled on the sck edge where sclk goes high; spi_mosi_o SHALL advance on the edge where sclk goes low, except after the last bit.
REQ-025 In HOLD (CS_HOLD cycles): sclk=0 and the chip select stays low.
REQ-026 On entry to GAP, the chip select SHALL go high, and rsp_valid_o SHALL be 1 for exactly one cycle with rsp_data_o = captured bits, assembled in the same bit order as transmitted.
REQ-027 rsp_data_o SHALL hold its value until the next response.
REQ-028 rsp_valid_o SHALL occur CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD + 1 cycles after the accept edge.
REQ-029 cmd_ready_o SHALL be asserted CS_GAP cycles after rsp_valid_o.
REQ-030 At most one chip select SHALL be low at any time; outside SETUP/SHIFT/HOLD all chip selects SHALL be high.
REQ-031 Back-to-back commands (cmd_valid_i held high) SHALL be separated by at least CS_GAP cycles with all chip selects high.

Reset
REQ-032 While rst=1, asynchronously: state IDLE, spi_cs_n_o all 1, spi_sclk_o=0, spi_mosi_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, cmd_ready_o=1.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid_o pulse; the first command after reset release SHALL complete normally.

Structure
REQ-034 The state enum and the default timing constants SHALL live in a shared package pga_pkg.
REQ-035 SCLK/bit timing SHALL be a sub-module spi_tick_gen, which produces the rise/fall ticks from CLK_DIV and is enabled only in SHIFT.

Verification
REQ-036 Defaults, miso looped to mosi, cmd ch=2 data=0xA5 -> cs_n=4'b1011 for 34 cycles, 8 sclk pulses, mosi bits 1,0,1,0,0,1,0,1, rsp_data=0xA5 at accept+35, ready at accept+37.
REQ-037 MSB_FIRST=0, miso tied 1, data=0x01 -> mosi first bit 1, rsp_data=0xFF, rsp_err=0.
REQ-038 cmd ch=5 with NUM_CH=4 -> no chip select falls, rsp_valid=1 and rsp_err=1 at accept+1, rsp_data=0.
REQ-039 cmd_valid held high with two commands (ch0=0x11, ch1=0x22) -> cs_n[0] and cs_n[1] never both low, >=2 high cycles between transfers.
REQ-040 rst pulsed at accept+10 -> all cs_n high and sclk low within the same cycle, no rsp_valid, next command completes with correct data.
REQ-041 DATA_W=16, CLK_DIV=1, data=0xBEEF -> SHIFT lasts 32 cycles, rsp at accept+35.
